temp_averager: RTL and testbench
================================

TEMP_AVERAGER -- requirements
Module: temp_averager

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 27000000, is the sampling interval in CLK cycles (1 s at 27 MHz); legal range is at least 4.
REQ-002 Port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port TEMPERATURE, input, 16 bits: raw signed two's-complement DS18B20 reading in 1/16 degC units, held stable by the sensor master between conversions.
REQ-005 Port CLEAR, input, 1 bit: synchronous flush request.
REQ-006 Port TEMP_AVG, output, 16 bits: signed 8-sample moving average, consumed by the PID measured-value input.
REQ-007 Port AVG_VALID, output, 1 bit: one-cycle strobe marking a new TEMP_AVG.
REQ-008 Port PRIMED, output, 1 bit: high once the buffer holds valid data.
REQ-009 Port FAULT, output, 1 bit: sticky out-of-range flag.
REQ-010 Port REJECT, output, 1 bit: one-cycle pulse on a discarded sample.

Function
REQ-011 A free-running tick counter shall count 0..SAMPLE_PERIOD-1 and wrap; the terminal count is the tick; the counter shall never pause.
REQ-012 The FSM states shall be WAIT, CHECK, UPDATE and OUTPUT.
REQ-013 WAIT->CHECK on the tick edge, which shall also register TEMPERATURE into the sample register.
REQ-014 In CHECK the sample is rejected if below 0xFC90 (-55 degC) or above 0x07D0 (+125 degC) in signed compare; on rejection FAULT shall set, REJECT shall pulse and the FSM shall return to WAIT.
REQ-015 In CHECK with PRIMED=0 a sample equal to 0x0550 (85 degC power-on value) shall be rejected with a REJECT pulse, FAULT unchanged, and the FSM shall return to WAIT; with PRIMED=1, 0x0550 is a normal sample.
REQ-016 An accepted sample shall move the FSM to UPDATE.
REQ-017 UPDATE with PRIMED=0 shall load all 8 buffer entries with the sample, set sum = sample*8, set ptr=0 and set PRIMED=1.
REQ-018 UPDATE with PRIMED=1 shall set sum = sum - buf[ptr] + sample, write buf[ptr] = sample and advance ptr modulo 8 (7 wraps to 0).
REQ-019 UPDATE shall always move to OUTPUT.
REQ-020 The sum register shall be 19-bit signed; no overflow is possible within the legal range.
REQ-021 OUTPUT shall register TEMP_AVG = sum arithmetically shifted right by 3 (floor toward -infinity, bits [18:3]), pulse AVG_VALID and return to WAIT.
REQ-022 AVG_VALID shall be high exactly one cycle, 3 edges after the capture edge; TEMP_AVG changes only with AVG_VALID and holds otherwise.
REQ-023 CLEAR shall override all FSM activity: next state WAIT, counter=0, ptr=0, sum=0, PRIMED=0, FAULT=0, AVG_VALID=0, REJECT=0, TEMP_AVG held.
REQ-024 If CLEAR and a tick occur on the same edge, CLEAR shall win and no sample is captured.
REQ-025 FAULT shall clear only by RST or CLEAR; FAULT shall not block later valid samples.

Reset
REQ-026 RST high shall immediately force TEMP_AVG=0, AVG_VALID=0, PRIMED=0, FAULT=0, REJECT=0, counter=0, ptr=0, sum=0, all buffer entries=0 and state WAIT.
REQ-027 RST asserted mid-pipeline (CHECK/UPDATE/OUTPUT) shall abort with no AVG_VALID pulse; after release, the first tick is SAMPLE_PERIOD cycles later.

Verification (SAMPLE_PERIOD=8)
REQ-028 Power-on artifact: TEMPERATURE=0x0550 at first tick -> REJECT pulse, PRIMED=0, FAULT=0, no AVG_VALID; next tick with 0x0190 -> PRIMED=1, TEMP_AVG=0x0190, AVG_VALID 3 edges after capture.
REQ-029 Running average: primed at 0x0190, next sample 0x0210 -> TEMP_AVG=0x01A0; eight consecutive 0x0210 samples -> TEMP_AVG=0x0210, ptr wrapped to 0.
REQ-030 Negative floor: prime with 0xFFF8, then sample 0xFFFF -> sum=-57, TEMP_AVG=0xFFF8.
REQ-031 Range fault: primed at 0x0190, sample 0x0800 -> FAULT=1, REJECT pulse, TEMP_AVG stays 0x0190; next sample 0x0190 -> accepted, FAULT stays 1; CLEAR -> FAULT=0, PRIMED=0.
REQ-032 Collision and abort: CLEAR coincident with tick -> no capture, counter=0; separately, RST pulse during UPDATE -> all outputs 0 at once, no AVG_VALID after release until a new accepted sample.

Source files
------------

// File: rtl/temp_averager.sv
// Eight-sample moving average of a DS18B20 temperature reading.
// A sample is taken once per SAMPLE_PERIOD, range-checked, folded into a running sum and published.
module temp_averager #(
    parameter int SAMPLE_PERIOD = 27000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] TEMPERATURE,
    input  logic        CLEAR,
    output logic [15:0] TEMP_AVG,
    output logic        AVG_VALID,
    output logic        PRIMED,
    output logic        FAULT,
    output logic        REJECT
);

    localparam int CW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {WAIT, CHECK, UPDATE, OUTPUT} state_t;

    state_t      state;
    logic [CW-1:0] count;
    logic [15:0] sample;
    logic [15:0] buffer [8];
    logic [2:0]  ptr;
    logic [18:0] sum;

    logic        tick;
    logic        out_of_range;
    logic        power_on_value;
    logic [18:0] sample_ext;
    logic [18:0] oldest_ext;

    always_comb begin
        tick           = (count == TERMINAL);
        // Legal DS18B20 range is -55 degC (0xFC90) to +125 degC (0x07D0).
        out_of_range   = ($signed(sample) < -16'sd880) || ($signed(sample) > 16'sd2000);
        power_on_value = !PRIMED && (sample == 16'h0550);
        sample_ext     = {{3{sample[15]}}, sample};
        oldest_ext     = {{3{buffer[ptr][15]}}, buffer[ptr]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= WAIT;
            count     <= '0;
            sample    <= '0;
            ptr       <= '0;
            sum       <= '0;
            TEMP_AVG  <= '0;
            AVG_VALID <= 1'b0;
            PRIMED    <= 1'b0;
            FAULT     <= 1'b0;
            REJECT    <= 1'b0;
            for (int i = 0; i < 8; i++) buffer[i] <= '0;
        end else if (CLEAR) begin
            state     <= WAIT;
            count     <= '0;
            ptr       <= '0;
            sum       <= '0;
            AVG_VALID <= 1'b0;
            PRIMED    <= 1'b0;
            FAULT     <= 1'b0;
            REJECT    <= 1'b0;
        end else begin
            count     <= tick ? '0 : count + 1'b1;
            AVG_VALID <= 1'b0;
            REJECT    <= 1'b0;
            case (state)
                WAIT: begin
                    if (tick) begin
                        sample <= TEMPERATURE;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (out_of_range) begin
                        FAULT  <= 1'b1;
                        REJECT <= 1'b1;
                        state  <= WAIT;
                    end else if (power_on_value) begin
                        REJECT <= 1'b1;
                        state  <= WAIT;
                    end else begin
                        state  <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (!PRIMED) begin
                        // First good sample fills the window so the average is valid at once.
                        for (int i = 0; i < 8; i++) buffer[i] <= sample;
                        sum    <= {sample, 3'b000};
                        ptr    <= '0;
                        PRIMED <= 1'b1;
                    end else begin
                        sum         <= sum - oldest_ext + sample_ext;
                        buffer[ptr] <= sample;
                        ptr         <= ptr + 1'b1;
                    end
                    state <= OUTPUT;
                end
                OUTPUT: begin
                    TEMP_AVG  <= sum[18:3];
                    AVG_VALID <= 1'b1;
                    state     <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_averager.sv
// Directed and randomized bench for temp_averager with SAMPLE_PERIOD=8.
// Expected averages come from a queue holding the last eight accepted samples.
module tb_temp_averager;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CLEAR;
    logic [15:0] TEMPERATURE;
    logic [15:0] TEMP_AVG;
    logic        AVG_VALID;
    logic        PRIMED;
    logic        FAULT;
    logic        REJECT;

    temp_averager #(.SAMPLE_PERIOD(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .TEMPERATURE(TEMPERATURE),
        .CLEAR(CLEAR),
        .TEMP_AVG(TEMP_AVG),
        .AVG_VALID(AVG_VALID),
        .PRIMED(PRIMED),
        .FAULT(FAULT),
        .REJECT(REJECT)
    );

    always #5 CLK = ~CLK;

    int          ncmp = 0;
    int          nerr = 0;
    int          tcnt = 0;
    bit          ticked;
    int          q[$];
    bit          m_primed = 1'b0;
    bit          m_fault = 1'b0;
    logic [15:0] m_avg = 16'h0000;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        ticked = !CLEAR && (tcnt == 7);
        tcnt   = CLEAR ? 0 : (tcnt + 1) % 8;
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, AVG_VALID, 1'b0);
        chk({tag, "_reject"}, REJECT, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_avg"}, TEMP_AVG, 16'h0000);
        chk({tag, "_valid"}, AVG_VALID, 1'b0);
        chk({tag, "_primed"}, PRIMED, 1'b0);
        chk({tag, "_fault"}, FAULT, 1'b0);
        chk({tag, "_reject"}, REJECT, 1'b0);
    endtask

    function automatic logic [15:0] model_avg();
        int s = 0;
        foreach (q[i]) s += q[i];
        return 16'(s >>> 3);
    endfunction

    task automatic wait_tick();
        ticked = 1'b0;
        while (!ticked) begin
            step();
            if (!ticked) chk_quiet("idle");
        end
    endtask

    task automatic do_sample(input logic [15:0] v);
        int sv;
        bit rej;
        bit rej_fault;
        TEMPERATURE = v;
        wait_tick();
        chk_quiet("capture");
        sv        = int'($signed(v));
        rej_fault = (sv < -880) || (sv > 2000);
        rej       = rej_fault || (!m_primed && v == 16'h0550);
        step();
        chk("reject", REJECT, rej);
        chk("valid_e1", AVG_VALID, 1'b0);
        if (rej_fault) m_fault = 1'b1;
        chk("fault", FAULT, m_fault);
        if (!rej) begin
            if (!m_primed) begin
                q.delete();
                repeat (8) q.push_back(sv);
                m_primed = 1'b1;
            end else begin
                void'(q.pop_front());
                q.push_back(sv);
            end
            m_avg = model_avg();
        end
        step();
        chk_quiet("e2");
        step();
        chk("valid_e3", AVG_VALID, !rej);
        chk("temp_avg", TEMP_AVG, m_avg);
        chk("primed", PRIMED, m_primed);
        step();
        chk("valid_e4", AVG_VALID, 1'b0);
        chk("temp_avg_hold", TEMP_AVG, m_avg);
    endtask

    task automatic do_clear();
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        m_primed = 1'b0;
        m_fault  = 1'b0;
        q.delete();
        chk("clear_fault", FAULT, 1'b0);
        chk("clear_primed", PRIMED, 1'b0);
        chk_quiet("clear");
        chk("clear_avg_hold", TEMP_AVG, m_avg);
    endtask

    initial begin
        int r;
        int sv;
        RST = 1'b0;
        CLEAR = 1'b0;
        TEMPERATURE = 16'h0000;
        #3 RST = 1'b1;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        tcnt = 0;

        // Power-on 85 degC artifact, then priming.
        do_sample(16'h0550);
        do_sample(16'h0190);
        // Running average and full window turnover.
        do_sample(16'h0210);
        chk("avg_01a0", TEMP_AVG, 16'h01A0);
        repeat (7) do_sample(16'h0210);
        chk("avg_0210", TEMP_AVG, 16'h0210);
        do_sample(16'h0100);

        // Range fault is sticky but does not block later samples.
        do_clear();
        do_sample(16'h0190);
        do_sample(16'h0800);
        chk("fault_hold_avg", TEMP_AVG, 16'h0190);
        do_sample(16'h0190);
        chk("fault_sticky", FAULT, 1'b1);
        do_sample(16'hFC8F);
        do_sample(16'hFC90);
        do_sample(16'h07D0);
        do_clear();

        // Negative values floor toward -infinity.
        do_sample(16'hFFF8);
        do_sample(16'hFFFF);
        chk("neg_floor", TEMP_AVG, 16'hFFF8);

        // CLEAR coincident with the tick: no capture.
        while (tcnt != 7) begin
            step();
            chk_quiet("pre_collision");
        end
        TEMPERATURE = 16'h0100;
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        m_primed = 1'b0;
        m_fault  = 1'b0;
        q.delete();
        repeat (7) begin
            step();
            chk_quiet("post_collision");
            chk("post_collision_primed", PRIMED, 1'b0);
        end
        do_sample(16'h0100);

        // Reset during UPDATE aborts the pipeline.
        do_sample(16'h0300);
        TEMPERATURE = 16'h0400;
        wait_tick();
        step();
        #2 RST = 1'b1;
        #1 chk_all_zero("rst_update");
        @(posedge CLK);
        #1 RST = 1'b0;
        tcnt = 0;
        m_primed = 1'b0;
        m_fault  = 1'b0;
        m_avg    = 16'h0000;
        q.delete();
        repeat (7) begin
            step();
            chk_quiet("post_rst");
        end
        chk_all_zero("post_rst_state");
        do_sample(16'h0400);

        // Randomized samples with occasional rejects, artifacts and flushes.
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) do_clear();
            if (r == 1) sv = 16'h0550;
            else if (r == 2) sv = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2001, 4000))
                                                             : -int'($urandom_range(881, 4000));
            else sv = int'($urandom_range(0, 2880)) - 880;
            do_sample(16'(sv));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
